// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types, ALU op encoding and LFSR helpers for the Simon Says datapath
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SETTLE,
    WAIT_ANS,
    JUDGE,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SQR = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Galois form: shift right, fold the taps in when a one drops out of bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR that advances one step when step is high
module lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] state
);

  // an all-zero state would lock up, so fall back to the default seed
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/alu_challenge_ctrl.sv
// rtl/alu_challenge_ctrl.sv - per-round operand generation, answer judging and scoring for the ALU challenge
module alu_challenge_ctrl
  import simon_pkg::*;
#(
  parameter int          NUM_ROUNDS     = 8,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       player_valid,
  input  logic [7:0] player_answer,
  input  logic [7:0] alu_out,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic [3:0] alu_select,
  output logic [3:0] round,
  output logic [3:0] score,
  output logic       busy,
  output logic       result_valid,
  output logic       correct,
  output logic       game_over
);

  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [25:0] TLIM       = 26'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  op_idx;
  logic [7:0]  expected;
  logic [25:0] tcount;
  logic        expired;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (state == GEN),
    .state (lfsr_q)
  );

  // operands are taken from the post-step value, matching what the LFSR will hold
  assign lfsr_d  = lfsr_next(lfsr_q);
  assign expired = (tcount == TLIM);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    game_over    = 1'b0;
    case (state)
      IDLE:     if (start) state_n = GEN;
      GEN:      begin busy = 1'b1; state_n = SETTLE; end
      SETTLE:   begin busy = 1'b1; state_n = WAIT_ANS; end
      WAIT_ANS: begin
        busy = 1'b1;
        if (player_valid || expired) state_n = JUDGE;
      end
      JUDGE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        state_n      = (round < LAST_ROUND) ? GEN : DONE;
      end
      DONE: begin
        game_over = 1'b1;
        if (start) state_n = GEN;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      operand_a  <= 8'h00;
      operand_b  <= 8'h00;
      alu_select <= 4'h0;
      round      <= 4'h0;
      score      <= 4'h0;
      correct    <= 1'b0;
      op_idx     <= 3'd0;
      expected   <= 8'h00;
      tcount     <= 26'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            round <= 4'd1;
            score <= 4'd0;
          end
        end
        GEN: begin
          operand_a  <= lfsr_d[7:0];
          operand_b  <= (lfsr_d[15:8] == 8'h00) ? 8'h01 : lfsr_d[15:8];
          alu_select <= {1'b0, op_idx};
          op_idx     <= (op_idx == OP_MOD[2:0]) ? 3'd0 : op_idx + 3'd1;
        end
        SETTLE: begin
          expected <= alu_out;
          tcount   <= 26'd0;
        end
        WAIT_ANS: begin
          // a real answer in the expiry cycle takes precedence over the timeout
          if (player_valid) begin
            correct <= (player_answer == expected);
            if (player_answer == expected) score <= score + 4'd1;
          end else if (expired) begin
            correct <= 1'b0;
          end else begin
            tcount <= tcount + 26'd1;
          end
        end
        JUDGE: begin
          if (round < LAST_ROUND) round <= round + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_challenge_ctrl.sv
// tb/tb_alu_challenge_ctrl.sv - directed bench for alu_challenge_ctrl with a behavioural ALU
module tb_alu_challenge_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0, pv = 1'b0;
  logic [7:0] ans = 8'h00;
  logic [7:0] alu_out, operand_a, operand_b;
  logic [3:0] alu_select, round, score;
  logic       busy, result_valid, correct, game_over;

  logic       start2 = 1'b0, pv2 = 1'b0;
  logic [7:0] ans2 = 8'h00;
  logic [7:0] alu_out2, operand_a2, operand_b2;
  logic [3:0] alu_select2, round2, score2;
  logic       busy2, result_valid2, correct2, game_over2;

  int checks = 0;
  int errors = 0;
  logic chk_b2 = 1'b0;

  alu_challenge_ctrl #(.NUM_ROUNDS(3), .SEED(16'hACE1), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .player_valid(pv), .player_answer(ans),
    .alu_out(alu_out), .operand_a(operand_a), .operand_b(operand_b), .alu_select(alu_select),
    .round(round), .score(score), .busy(busy), .result_valid(result_valid),
    .correct(correct), .game_over(game_over));

  alu_challenge_ctrl #(.NUM_ROUNDS(2), .SEED(16'h00F0), .TIMEOUT_CYCLES(10)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .player_valid(pv2), .player_answer(ans2),
    .alu_out(alu_out2), .operand_a(operand_a2), .operand_b(operand_b2), .alu_select(alu_select2),
    .round(round2), .score(score2), .busy(busy2), .result_valid(result_valid2),
    .correct(correct2), .game_over(game_over2));

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [15:0] p;
    p = 16'(a) * 16'(a);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return p[7:0];
      4'd3: return (b == 8'h00) ? 8'hFF : a / b;
      4'd4: return (b == 8'h00) ? 8'hFF : a % b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out  = alu(operand_a, operand_b, alu_select);
  assign alu_out2 = alu(operand_a2, operand_b2, alu_select2);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_b2) chk("b2_nonzero", 16'(operand_b2 != 8'h00), 16'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, 16'(operand_a), 16'h0);
    chk({tag, "_b"}, 16'(operand_b), 16'h0);
    chk({tag, "_sel"}, 16'(alu_select), 16'h0);
    chk({tag, "_round"}, 16'(round), 16'h0);
    chk({tag, "_score"}, 16'(score), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_rv"}, 16'(result_valid), 16'h0);
    chk({tag, "_correct"}, 16'(correct), 16'h0);
    chk({tag, "_over"}, 16'(game_over), 16'h0);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    check_zero("reset");

    // game 1, round 1: E270 -> a=70 b=E2 add -> 52
    start = 1'b1; tick(); start = 1'b0;
    chk("r1_busy", 16'(busy), 16'd1);
    chk("r1_round", 16'(round), 16'd1);
    tick();
    chk("r1_a", 16'(operand_a), 16'h70);
    chk("r1_b", 16'(operand_b), 16'hE2);
    chk("r1_sel", 16'(alu_select), 16'd0);
    tick();
    chk("r1_wait_rv", 16'(result_valid), 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_round", 16'(round), 16'd1);
    chk("busy_start_rv", 16'(result_valid), 16'd0);
    pv = 1'b1; ans = 8'h52; tick(); pv = 1'b0;
    chk("r1_rv", 16'(result_valid), 16'd1);
    chk("r1_correct", 16'(correct), 16'd1);
    chk("r1_score", 16'(score), 16'd1);
    tick();
    chk("r1_rv_pulse", 16'(result_valid), 16'd0);
    chk("r2_round", 16'(round), 16'd2);
    chk("r1_correct_hold", 16'(correct), 16'd1);

    // round 2: 7138 -> a=38 b=71 sub -> C7; answer wrong
    tick();
    chk("r2_a", 16'(operand_a), 16'h38);
    chk("r2_b", 16'(operand_b), 16'h71);
    chk("r2_sel", 16'(alu_select), 16'd1);
    tick();
    pv = 1'b1; ans = 8'hC8; tick(); pv = 1'b0;
    chk("r2_rv", 16'(result_valid), 16'd1);
    chk("r2_correct", 16'(correct), 16'd0);
    chk("r2_score", 16'(score), 16'd1);

    // round 3: 389C -> a=9C b=38 square; player_valid during GEN ignored, then timeout
    tick();
    chk("r3_round", 16'(round), 16'd3);
    pv = 1'b1; ans = 8'h10; tick(); pv = 1'b0;
    chk("r3_a", 16'(operand_a), 16'h9C);
    chk("r3_b", 16'(operand_b), 16'h38);
    chk("r3_sel", 16'(alu_select), 16'd2);
    chk("r3_gen_pv_ignored", 16'(result_valid), 16'd0);
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("r3_no_early_judge", 16'(result_valid), 16'd0);
    end
    tick();
    chk("r3_timeout_rv", 16'(result_valid), 16'd1);
    chk("r3_timeout_correct", 16'(correct), 16'd0);
    chk("r3_score", 16'(score), 16'd1);
    tick();
    chk("done_over", 16'(game_over), 16'd1);
    chk("done_busy", 16'(busy), 16'd0);
    chk("done_round", 16'(round), 16'd3);
    chk("done_score", 16'(score), 16'd1);
    tick();
    chk("done_hold", 16'(game_over), 16'd1);

    // game 2 continues LFSR/op index: 1C4E -> a=4E b=1C div -> 02
    start = 1'b1; tick(); start = 1'b0;
    chk("g2_round", 16'(round), 16'd1);
    chk("g2_score", 16'(score), 16'd0);
    chk("g2_over", 16'(game_over), 16'd0);
    tick();
    chk("g2_a", 16'(operand_a), 16'h4E);
    chk("g2_b", 16'(operand_b), 16'h1C);
    chk("g2_sel", 16'(alu_select), 16'd3);
    tick();
    for (int i = 1; i <= 9; i++) tick();
    chk("g2_expiry_still_wait", 16'(result_valid), 16'd0);
    chk("g2_expiry_busy", 16'(busy), 16'd1);
    pv = 1'b1; ans = 8'h02; tick(); pv = 1'b0;
    chk("g2_expiry_rv", 16'(result_valid), 16'd1);
    chk("g2_expiry_correct", 16'(correct), 16'd1);
    chk("g2_expiry_score", 16'(score), 16'd1);

    // round 2 of game 2: 0E27 -> a=27 b=0E mod; reset while waiting
    tick(); tick();
    chk("g2r2_a", 16'(operand_a), 16'h27);
    chk("g2r2_b", 16'(operand_b), 16'h0E);
    chk("g2r2_sel", 16'(alu_select), 16'd4);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_zero("midreset");
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("reseed_a", 16'(operand_a), 16'h70);
    chk("reseed_b", 16'(operand_b), 16'hE2);
    chk("reseed_sel", 16'(alu_select), 16'd0);
    reset = 1'b1; tick(); reset = 1'b0;

    // zero high byte forced to 01: 00F0 -> 0078 -> 003C
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick();
    chk("s2_a", 16'(operand_a2), 16'h78);
    chk("s2_b", 16'(operand_b2), 16'h01);
    chk("s2_sel", 16'(alu_select2), 16'd0);
    chk_b2 = 1'b1;
    tick();
    pv2 = 1'b1; ans2 = 8'h79; tick(); pv2 = 1'b0;
    chk("s2_r1_correct", 16'(correct2), 16'd1);
    chk("s2_r1_rv", 16'(result_valid2), 16'd1);
    tick(); tick();
    chk("s2_r2_a", 16'(operand_a2), 16'h3C);
    chk("s2_r2_b", 16'(operand_b2), 16'h01);
    chk("s2_r2_sel", 16'(alu_select2), 16'd1);
    tick();
    pv2 = 1'b1; ans2 = 8'h3B; tick(); pv2 = 1'b0;
    chk("s2_r2_correct", 16'(correct2), 16'd1);
    chk("s2_score", 16'(score2), 16'd2);
    tick();
    chk("s2_over", 16'(game_over2), 16'd1);
    chk("s2_round", 16'(round2), 16'd2);
    chk_b2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_challenge_ctrl.md
# alu_challenge_ctrl

Upstream round controller for the 8-bit ALU in the Simon Says datapath. Each round it generates a pseudo-random operand pair and an operation select, drives them to the ALU, and captures the ALU result as the expected answer. It then waits for the player's answer or a timeout, judges it, and keeps score across a fixed number of rounds.

## Interface
Parameters:
- NUM_ROUNDS, 8: rounds per game; legal range 1..15.
- SEED, 16'hACE1: LFSR reset value; 16'h0000 is replaced by 16'hACE1.
- TIMEOUT_CYCLES, 50_000_000: cycles allowed in WAIT_ANS before the answer is judged wrong; legal range 1..2^26-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a game; sampled only in IDLE or DONE.
- player_valid  in  1  player_answer is valid this cycle; sampled only in WAIT_ANS.
- player_answer  in  8  player's answer.
- alu_out  in  8  ALU result, combinational from operand_a/operand_b/alu_select.
- operand_a  out  8  ALU operand A; registered.
- operand_b  out  8  ALU operand B; registered; never 0.
- alu_select  out  4  ALU op: 0 add, 1 sub, 2 square, 3 div, 4 mod.
- round  out  4  current round, 1..NUM_ROUNDS; 0 in IDLE.
- score  out  4  correct answers this game.
- busy  out  1  high in GEN, SETTLE, WAIT_ANS, JUDGE.
- result_valid  out  1  high for exactly one cycle, in JUDGE.
- correct  out  1  verdict; valid while result_valid is high; holds until the next JUDGE.
- game_over  out  1  high in DONE.

## Operation
- States: IDLE, GEN, SETTLE, WAIT_ANS, JUDGE, DONE.
- Reset values: all outputs 0. State is IDLE, the LFSR holds SEED, the op index is 0, and the timeout counter is 0.
- IDLE: on start, go to GEN, set round=1 and clear score.
- GEN (1 cycle):
  - Step the LFSR once. It is a 16-bit Galois LFSR: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - From the new value, register operand_a = lfsr[7:0] and operand_b = lfsr[15:8]. If operand_b would be 8'h00, register 8'h01 instead.
  - Register alu_select = op index. The op index then increments and wraps 4→0.
  - Go to SETTLE.
- SETTLE (1 cycle): the ALU settles combinationally. Capture expected = alu_out at the end of the cycle and go to WAIT_ANS.
- WAIT_ANS:
  - Counts cycles.
  - player_valid=1 → go to JUDGE with answer = player_answer.
  - Counter reaches TIMEOUT_CYCLES with no player_valid → go to JUDGE with a forced-wrong verdict.
  - player_valid arriving in the expiry cycle wins over the timeout.
- JUDGE (1 cycle):
  - result_valid=1 and correct = (answer == expected) and not timed out.
  - score was incremented on entry when correct.
  - If round < NUM_ROUNDS: increment round and go to GEN. Otherwise go to DONE.
- DONE: game_over=1, with round and score held. start → restart as from IDLE; the LFSR and op index continue and are not reseeded.
- start while busy is ignored. player_valid outside WAIT_ANS is ignored.
- operand_a, operand_b and alu_select stay stable from the end of GEN until the next GEN.
- reset at any cycle, including mid-round, returns everything to reset values at that edge. No partial score survives.

## Timing
- start high at edge t → GEN during t+1, SETTLE t+2, WAIT_ANS from t+3.
- Operands are valid at the ALU from cycle t+2.
- player_valid high at edge k in WAIT_ANS → JUDGE during k+1, with result_valid, correct and score updated.
- Next GEN at k+2, or game_over=1 at k+2 after the final round.
- Timeout: with no answer, JUDGE occurs TIMEOUT_CYCLES cycles after WAIT_ANS entry.
- Minimum round length: 4 cycles (GEN, SETTLE, 1 WAIT_ANS, JUDGE).

## Structure
- Shared package simon_pkg holds:
  - the state enum;
  - ALU op constants OP_ADD=0, OP_SUB=1, OP_SQR=2, OP_DIV=3, OP_MOD=4 (the ALU select encoding);
  - LFSR_TAPS=16'hB400 and DEFAULT_SEED=16'hACE1.
- Natural sub-module: lfsr16 (clk, reset, step, seed param, 16-bit state out). It is reusable for Simon pattern generation.

## Test plan
- Reset, SEED=16'hACE1, pulse start → round 1: operand_a=8'h70, operand_b=8'hE2, alu_select=0. ALU gives 8'h52; player answers 8'h52 → result_valid for 1 cycle, correct=1, score=1.
- Same setup, player answers 8'h53 → correct=0, score=0, round advances to 2 with alu_select=1.
- SEED=16'h00F0 → first GEN gives operand_a=8'h78 and raw operand_b=8'h00, forced to 8'h01. Expected 8'h79. No cycle across a full game shows operand_b=0.
- TIMEOUT_CYCLES=10, no player_valid → JUDGE exactly 10 cycles after WAIT_ANS entry, correct=0. A separate run with player_valid in the expiry cycle and the right answer → correct=1.
- NUM_ROUNDS=3, all answers correct → alu_select sequence 0,1,2, then game_over=1 with score=3 and round=3. start in DONE → round=1, score=0, alu_select=3.
- reset asserted in WAIT_ANS of round 2 → next cycle all outputs 0 and state IDLE. player_valid and start pulses while busy have no effect.
